// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with kbdclk glitch filter, frame decoder and first-word-fall-through word FIFO.
// Define KBD_PARITY_CHK_EN to check odd parity; by default the parity bit is sampled and ignored.
module ps2_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              kbdclk,
  input  logic                              kbddata,
  output logic [DATA_W-1:0]                 word,
  output logic                              word_valid,
  input  logic                              word_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              frame_err,
  output logic                              overflow,
  output logic                              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Stage p0/p1: two-flop synchronizers, preset high so reset release sees an idle bus
  logic kbdclk_p0, kbdclk_p1, kbddata_p0, kbddata_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbdclk_p0  <= 1'b1;
      kbdclk_p1  <= 1'b1;
      kbddata_p0 <= 1'b1;
      kbddata_p1 <= 1'b1;
    end else begin
      kbdclk_p0  <= kbdclk;
      kbdclk_p1  <= kbdclk_p0;
      kbddata_p0 <= kbddata;
      kbddata_p1 <= kbddata_p0;
    end
  end

  // Stage p2: glitch filter; fall pulses in the cycle kbdclk_f first reads low
  logic          kbdclk_f;
  logic          fall;
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbdclk_f <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (kbdclk_p1 == kbdclk_f) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        kbdclk_f <= kbdclk_p1;
        filt_cnt <= '0;
        fall     <= ~kbdclk_p1;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // Frame decoder, stepped by fall; to_cnt counts cycles since the most recent fall
  state_t            state;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     to_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_ok;
  logic              push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (fall)
        to_cnt <= TW'(1);
      else if (state == IDLE)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;

      if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!kbddata_p1) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (bit_cnt == BW'(DATA_W - 1))
              state <= PARITY;
            else
              bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: state <= STOP;
          STOP: begin
            state <= IDLE;
            if (!(kbddata_p1 && par_ok))
              frame_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fall && state == DATA)
      shreg[bit_cnt] <= kbddata_p1;
  end

`ifdef KBD_PARITY_CHK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (fall && state == PARITY)
      par_bit <= kbddata_p1;
  end

  assign par_ok = ^{shreg, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  assign busy = (state != IDLE);
  assign push = fall && (state == STOP) && kbddata_p1 && par_ok;

  // Word FIFO: head is read straight from storage, so a push is visible the next cycle
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              full, pop, wr_en;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = word_valid & word_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign word_valid = (count != '0);
  assign word       = word_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames bit by bit and scoreboards the FIFO output.
module tb_ps2_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int FL    = 4;
  localparam int TO    = 5000;
  localparam int HALF  = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          kbdclk, kbddata;
  logic [DW-1:0] word;
  logic          word_valid, word_ready;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic          frame_err, overflow, busy;

  ps2_rx_fifo #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FILT_LEN(FL), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .kbdclk(kbdclk), .kbddata(kbddata),
    .word(word), .word_valid(word_valid), .word_ready(word_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int t_fall = 0;
  int ferr_cnt = 0, ferr_cyc = 0, ovf_cnt = 0, wv_rise_cyc = 0;
  logic wv_prev = 1'b0;
  logic busy_seen = 1'b0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
    end
    if (overflow) ovf_cnt++;
    if (word_valid && !wv_prev) wv_rise_cyc = cyc;
    wv_prev = word_valid;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    kbddata = b;
    repeat (HALF) @(negedge clk);
    kbdclk = 1'b0;
    t_fall = cyc;
    repeat (HALF) @(negedge clk);
    kbdclk = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    kbddata = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic drain(input int n);
    logic [DW-1:0] e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      chk("pop_valid", 32'(word_valid), 32'd1);
      chk("pop_word", 32'(word), 32'(e));
      word_ready = 1'b1;
      @(negedge clk);
    end
    word_ready = 1'b0;
  endtask

  initial begin
    int bf, bo, t_last;
    logic [DW-1:0] d;
    rst = 1'b1; kbdclk = 1'b1; kbddata = 1'b1; word_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // single good frame, latency from the stop-bit fall
    bf = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    exp_q.push_back(8'h1C);
    chk("t1_latency", 32'(wv_rise_cyc), 32'(t_fall + FL + 3));
    chk("t1_count", 32'(fifo_count), 32'd1);
    chk("t1_no_err", 32'(ferr_cnt - bf), 32'd0);
    drain(1);
    chk("t1_empty", 32'(fifo_count), 32'd0);

    word_ready = 1'b1;
    repeat (3) @(negedge clk);
    word_ready = 1'b0;
    chk("ready_empty_count", 32'(fifo_count), 32'd0);
    chk("ready_empty_valid", 32'(word_valid), 32'd0);

    // wrong parity
    bf = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef KBD_PARITY_CHK_EN
    chk("par_err", 32'(ferr_cnt - bf), 32'd1);
    chk("par_count", 32'(fifo_count), 32'd0);
`else
    exp_q.push_back(8'h1C);
    chk("par_ignored_err", 32'(ferr_cnt - bf), 32'd0);
    drain(1);
`endif

    // fill to full, fifth frame overflows
    for (int i = 1; i <= 5; i++) begin
      d = DW'(i);
      bo = ovf_cnt;
      send_frame(d, ~^d, 1'b1);
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(d);
        chk("fill_no_ovf", 32'(ovf_cnt - bo), 32'd0);
      end else begin
        chk("fill_ovf", 32'(ovf_cnt - bo), 32'd1);
      end
    end
    chk("full_count", 32'(fifo_count), 32'(DEPTH));
    drain(4);
    chk("drained_count", 32'(fifo_count), 32'd0);

    // timeout after start + 3 data bits
    bf = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    t_last = t_fall;
    chk("to_busy_mid", 32'(busy), 32'd1);
    for (int i = 0; i < TO + 100 && ferr_cnt == bf; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("to_err_count", 32'(ferr_cnt - bf), 32'd1);
    chk("to_err_cycle", 32'(ferr_cyc), 32'(t_last + FL + 2 + TO));
    chk("to_busy", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1);
    exp_q.push_back(8'h5A);
    drain(1);

    // 2-cycle glitch, then bad stop bit
    bf = ferr_cnt;
    busy_seen = 1'b0;
    kbdclk = 1'b0;
    repeat (2) @(negedge clk);
    kbdclk = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_busy", 32'(busy_seen), 32'd0);
    chk("glitch_err", 32'(ferr_cnt - bf), 32'd0);
    send_frame(8'hF0, 1'b1, 1'b0);
    chk("stop_err", 32'(ferr_cnt - bf), 32'd1);
    chk("stop_count", 32'(fifo_count), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);

    // reset mid-frame with two words buffered
    for (int i = 0; i < 2; i++) begin
      d = DW'(8'h31 + i);
      send_frame(d, ~^d, 1'b1);
      exp_q.push_back(d);
    end
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    bf = ferr_cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(word_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_no_err", 32'(ferr_cnt - bf), 32'd0);
    send_frame(8'h12, 1'b1, 1'b1);
    exp_q.push_back(8'h12);
    drain(1);
    chk("final_count", 32'(fifo_count), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
